// File: rtl/dma_channel_scheduler_pkg.sv
// Shared types and helpers for the DMA channel scheduler: FSM state encoding,
// length width and the round-robin pick function.
package dma_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPACE_WAIT,
        START,
        XFER,
        DONE
    } sched_state_t;

    localparam int unsigned CH_LEN_W = 6;
    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned PTR_W    = 3;

    // One-hot grant of the first set request searching upward from ptr+1, with wrap.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                  input logic [PTR_W-1:0]  ptr,
                                                  input int unsigned       num_ch);
        logic [MAX_CH-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            if (k <= num_ch) begin
                idx = (32'(ptr) + k) % num_ch;
                if (!found && req[idx[PTR_W-1:0]]) begin
                    grant[idx[PTR_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/dma_channel_scheduler_rr_arbiter.sv
// Round-robin picker over NUM_CH requests; the pointer moves to the serviced
// channel when upd is strobed.
module dma_channel_scheduler_rr_arbiter
    import dma_channel_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              upd,
    input  logic [PTR_W-1:0]  upd_idx,
    output logic [NUM_CH-1:0] grant_c
);

    logic [PTR_W-1:0]  ptr;
    logic [MAX_CH-1:0] req_ext;

    assign req_ext = MAX_CH'(req);
    assign grant_c = NUM_CH'(rr_pick(req_ext, ptr, NUM_CH));

    // Last-served channel; resets to NUM_CH-1 so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PTR_W'(NUM_CH - 1);
        end else if (upd) begin
            ptr <= upd_idx;
        end
    end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Schedules the CoreSystem DMA master across NUM_CH channels: round-robin grant,
// FIFO space check, start pulse, word counting and per-channel completion.
module dma_channel_scheduler
    import dma_channel_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_CH-1:0]          i_ch_req,
    input  logic [NUM_CH*32-1:0]       i_ch_addr,
    input  logic [NUM_CH*CH_LEN_W-1:0] i_ch_len,
    input  logic [CH_LEN_W-1:0]        i_fifo_count,
    input  logic                       i_word_valid,
    output logic                       o_CoreSystemStart,
    output logic [CH_LEN_W-1:0]        o_RCC_BUFFER_LENGTH,
    output logic [15:0]                o_RCC_DMA_ADDR_HIGH,
    output logic [15:0]                o_RCC_DMA_ADDR_LOW,
    output logic [NUM_CH-1:0]          o_ch_grant,
    output logic [NUM_CH-1:0]          o_ch_done,
    output logic                       o_done_err,
    output logic                       o_busy
);

    localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    sched_state_t          state;
    logic [TO_W-1:0]       to_cnt;
    logic [CH_LEN_W-1:0]   word_cnt;
    logic [CH_LEN_W-1:0]   cnt_inc;
    logic [PTR_W-1:0]      g_idx;
    logic [NUM_CH-1:0]     pick;
    logic [PTR_W-1:0]      pick_idx;
    logic [CH_LEN_W-1:0]   sel_len;
    logic [31:0]           sel_addr;
    logic                  fits;
    logic                  too_long;
    logic                  to_hit;
    logic                  req_lost;
    logic                  rr_upd;

    assign rr_upd   = (state == DONE);
    assign cnt_inc  = word_cnt + CH_LEN_W'(1);
    // Sum in 7 bits so a large occupancy can never wrap into "room available".
    assign fits     = (7'(i_fifo_count) + 7'(o_RCC_BUFFER_LENGTH)) <= 7'(FIFO_DEPTH);
    assign too_long = 7'(o_RCC_BUFFER_LENGTH) > 7'(FIFO_DEPTH);
    assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign req_lost = ((i_ch_req & o_ch_grant) == '0);

    dma_channel_scheduler_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (HCLK),
        .rst     (HRESET),
        .req     (i_ch_req),
        .upd     (rr_upd),
        .upd_idx (g_idx),
        .grant_c (pick)
    );

    // Index, length and address of the channel the arbiter is offering.
    always_comb begin
        pick_idx = '0;
        sel_len  = '0;
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
                sel_len  = i_ch_len[CH_LEN_W*i +: CH_LEN_W];
                sel_addr = i_ch_addr[32*i +: 32];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state               <= IDLE;
            to_cnt              <= '0;
            word_cnt            <= '0;
            g_idx               <= '0;
            o_CoreSystemStart   <= 1'b0;
            o_RCC_BUFFER_LENGTH <= '0;
            o_RCC_DMA_ADDR_HIGH <= '0;
            o_RCC_DMA_ADDR_LOW  <= '0;
            o_ch_grant          <= '0;
            o_ch_done           <= '0;
            o_done_err          <= 1'b0;
            o_busy              <= 1'b0;
        end else begin
            o_CoreSystemStart <= 1'b0;
            o_ch_done         <= '0;
            case (state)
                IDLE: begin
                    if (|i_ch_req) begin
                        o_ch_grant          <= pick;
                        g_idx               <= pick_idx;
                        o_RCC_BUFFER_LENGTH <= sel_len;
                        o_RCC_DMA_ADDR_HIGH <= sel_addr[31:16];
                        o_RCC_DMA_ADDR_LOW  <= sel_addr[15:0];
                        to_cnt              <= '0;
                        o_busy              <= 1'b1;
                        state               <= SPACE_WAIT;
                    end
                end
                SPACE_WAIT: begin
                    if (o_RCC_BUFFER_LENGTH == '0 || too_long) begin
                        o_ch_done  <= o_ch_grant;
                        o_ch_grant <= '0;
                        o_done_err <= too_long;
                        state      <= DONE;
                    end else if (fits) begin
                        o_CoreSystemStart <= 1'b1;
                        state             <= START;
                    end else if (req_lost) begin
                        o_ch_grant <= '0;
                        o_busy     <= 1'b0;
                        state      <= IDLE;
                    end else if (to_hit) begin
                        o_ch_done  <= o_ch_grant;
                        o_ch_grant <= '0;
                        o_done_err <= 1'b1;
                        state      <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                START: begin
                    word_cnt <= '0;
                    to_cnt   <= '0;
                    state    <= XFER;
                end
                XFER: begin
                    // Completion uses the incremented count so the last word ends XFER.
                    if (i_word_valid) begin
                        word_cnt <= cnt_inc;
                        to_cnt   <= '0;
                        if (cnt_inc == o_RCC_BUFFER_LENGTH) begin
                            o_ch_done  <= o_ch_grant;
                            o_ch_grant <= '0;
                            o_done_err <= 1'b0;
                            state      <= DONE;
                        end
                    end else if (to_hit) begin
                        o_ch_done  <= o_ch_grant;
                        o_ch_grant <= '0;
                        o_done_err <= 1'b1;
                        state      <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    o_done_err <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    o_ch_grant <= '0;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
